button_debouncer: RTL and testbench

- Conditions the raw push-button input on ui_in and produces clean, single-cycle event pulses for the downstream counter's increment input.
- Contains a 2-flop synchronizer, a stable-time filter, and an auto-repeat state machine that emits periodic pulses while the button is held.
- Sits directly upstream of the counter stage inside the top-level wrapper.

---
 rtl/button_debouncer.sv | 154 +++++++++++++++
 tb/tb_button_debouncer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stable-time filter and an
// auto-repeat FSM producing single-cycle press/release/repeat/event pulses.
module button_debouncer #(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic enable,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic event_pulse
);

  localparam int FW      = $clog2(STABLE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX);

  localparam logic [FW-1:0] FILT_LAST  = FW'(STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_ONE   = FW'(32'd1);
  localparam logic [FW-1:0] FILT_ZERO  = FW'(32'd0);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] RPT_ONE    = RW'(32'd1);
  localparam logic [RW-1:0] RPT_ZERO   = RW'(32'd0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          event_q, event_d;

  logic mismatch;
  logic flip;
  logic rise;
  logic fall;

  // Synchronizer and stable-time filter; pulses gated by enable, filter is not.
  always_comb begin
    s1_d       = btn_in;
    s2_d       = s1_q;
    level_d    = level_q;
    filt_cnt_d = filt_cnt_q;
    mismatch   = (s2_q != level_q);
    flip       = mismatch && (filt_cnt_q == FILT_LAST);
    rise       = flip && !level_q;
    fall       = flip && level_q;
    if (!mismatch) begin
      filt_cnt_d = FILT_ZERO;
    end else if (flip) begin
      filt_cnt_d = FILT_ZERO;
      level_d    = ~level_q;
    end else begin
      filt_cnt_d = filt_cnt_q + FILT_ONE;
    end
    press_d   = rise && enable;
    release_d = fall && enable;
  end

  // Auto-repeat FSM; an abort (fall, enable low, repeat_en low) beats a due repeat.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && enable && repeat_en) begin
          state_d   = DELAY;
          rpt_cnt_d = RPT_ZERO;
        end else begin
          state_d   = IDLE;
        end
      end
      DELAY: begin
        if (fall || !enable || !repeat_en) begin
          state_d   = IDLE;
          rpt_cnt_d = RPT_ZERO;
        end else if (rpt_cnt_q == DELAY_LAST) begin
          state_d   = REPEAT;
          rpt_cnt_d = RPT_ZERO;
          repeat_d  = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
        end
      end
      REPEAT: begin
        if (fall || !enable || !repeat_en) begin
          state_d   = IDLE;
          rpt_cnt_d = RPT_ZERO;
        end else if (rpt_cnt_q == RATE_LAST) begin
          rpt_cnt_d = RPT_ZERO;
          repeat_d  = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = RPT_ZERO;
      end
    endcase
    event_d = press_d | repeat_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      level_q    <= 1'b0;
      filt_cnt_q <= FILT_ZERO;
      state_q    <= IDLE;
      rpt_cnt_q  <= RPT_ZERO;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      level_q    <= level_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      rpt_cnt_q  <= rpt_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      event_q    <= event_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign event_pulse   = event_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_RATE=5; edges are numbered from 1 after each reset release.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic btn_in;
  logic enable;
  logic repeat_en;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic event_pulse;

  int n_cmp;
  int n_err;

  button_debouncer #(
    .STABLE_CYCLES(8),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .enable       (enable),
    .repeat_en    (repeat_en),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .event_pulse  (event_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare all outputs a little after it.
  task automatic tick_check(input string tag, input int e, input logic lvl,
                            input logic pr, input logic rl, input logic rp);
    @(posedge clk);
    #1;
    check_eq($sformatf("%s e%0d level", tag, e), {31'd0, btn_level}, {31'd0, lvl});
    check_eq($sformatf("%s e%0d press", tag, e), {31'd0, press_pulse}, {31'd0, pr});
    check_eq($sformatf("%s e%0d release", tag, e), {31'd0, release_pulse}, {31'd0, rl});
    check_eq($sformatf("%s e%0d repeat", tag, e), {31'd0, repeat_pulse}, {31'd0, rp});
    check_eq($sformatf("%s e%0d event", tag, e), {31'd0, event_pulse}, {31'd0, pr | rp});
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    btn_in    = 1'b0;
    enable    = 1'b1;
    repeat_en = 1'b0;
    for (int i = 0; i < 2; i++) tick_check(tag, -i, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic lvl, pr, rl, rp;
    n_cmp = 0;
    n_err = 0;

    // Reset with idle button, then a few idle edges.
    do_reset("rst");
    for (int e = 1; e <= 3; e++) tick_check("rst_idle", e, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold without repeat: press once at edge 10.
    do_reset("rst_hold");
    for (int e = 1; e <= 40; e++) begin
      btn_in = 1'b1;
      tick_check("hold", e, (e >= 10), (e == 10), 1'b0, 1'b0);
    end

    // Bounce bursts, then a 7-cycle pulse (rejected), then an 8-cycle pulse.
    do_reset("rst_bounce");
    for (int e = 1; e <= 75; e++) begin
      btn_in = ((e <= 20) && (((e - 1) % 5) < 3)) || (e >= 26 && e <= 32) || (e >= 50 && e <= 57);
      tick_check("bounce", e, (e >= 59 && e < 67), (e == 59), (e == 67), 1'b0);
    end

    // Hold with auto-repeat; fall lands on a due repeat edge and wins.
    do_reset("rst_rpt");
    for (int e = 1; e <= 70; e++) begin
      btn_in    = (e < 46);
      repeat_en = 1'b1;
      lvl = (e >= 10 && e < 55);
      rp  = (e >= 30 && e <= 50 && ((e - 30) % 5) == 0);
      tick_check("repeat", e, lvl, (e == 10), (e == 55), rp);
    end

    // Enable low suppresses pulses; level still tracks; re-enable needs a new press.
    do_reset("rst_en");
    for (int e = 1; e <= 75; e++) begin
      enable    = (e >= 15 && e < 40) || (e >= 55);
      btn_in    = (e <= 40) || (e >= 61);
      repeat_en = 1'b1;
      lvl = (e >= 10 && e < 50) || (e >= 70);
      tick_check("enable", e, lvl, (e == 70), 1'b0, 1'b0);
    end

    // Reset while held with repeat active; re-debounced press at edge 45.
    do_reset("rst_mid");
    for (int e = 1; e <= 50; e++) begin
      btn_in    = 1'b1;
      repeat_en = 1'b1;
      enable    = 1'b1;
      rst       = (e >= 33 && e <= 35);
      if (e < 33) begin
        lvl = (e >= 10); pr = (e == 10); rp = (e == 30);
      end else begin
        lvl = (e >= 45); pr = (e == 45); rp = 1'b0;
      end
      rl = 1'b0;
      tick_check("midrst", e, lvl, pr, rl, rp);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
